// File: rtl/regfile_wb_arb.sv
// Write-back arbiter for the register-file write port: merges unbuffered ALU results
// with a FIFO of long-latency results and keeps a pending-destination scoreboard.
module regfile_wb_arb #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_LIM = 4
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [31:0]     pend,
    output logic            wen,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    output logic            dbg_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_t;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high at
    // the rising edge; producers hold valid and payload stable until that cycle.

    state_t          r_state;
    logic [SW-1:0]   r_sc;
    logic [XLEN-1:0] r_data_mem [DEPTH];
    logic [4:0]      r_rd_mem   [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_pend;
    logic            r_wen;
    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_sel_a;
    logic            w_bypass;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic [31:0]     w_pend_nxt;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign b_ready  = !w_full && !srst;
    assign a_ready  = (r_state == ST_NORMAL) || srst;
    assign w_push   = b_valid && b_ready;
    assign w_sel_a  = (r_state == ST_NORMAL) && a_valid;
    assign w_pop    = !w_empty && ((r_state == ST_FORCE) || !a_valid);
    assign w_bypass = (r_state == ST_NORMAL) && !w_empty && a_valid;

    assign w_sel_rd   = w_sel_a ? a_rd   : r_rd_mem[r_rptr];
    assign w_sel_data = w_sel_a ? a_data : r_data_mem[r_rptr];

    assign pend      = r_pend;
    assign rs1_busy  = r_pend[rs1];
    assign rs2_busy  = r_pend[rs2];
    assign wen       = r_wen;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign dbg_state = r_state;

    // Clear happens on the edge the register file captures the write; a same-edge set wins.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_wen) begin
            w_pend_nxt[r_waddr] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            w_pend_nxt[iss_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_mem[r_wptr] <= b_data;
            r_rd_mem[r_wptr]   <= b_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_NORMAL;
            r_sc    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_pend  <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_pend  <= w_pend_nxt;

            if (w_sel_a || w_pop) begin
                r_wen   <= (w_sel_rd != 5'd0);
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end else begin
                r_wen <= 1'b0;
            end

            // sc counts consecutive cycles the FIFO head is passed over in favour of A.
            case (r_state)
                ST_NORMAL: begin
                    if (w_bypass) begin
                        if (r_sc == SW'(STARVE_LIM - 1)) begin
                            r_state <= ST_FORCE;
                            r_sc    <= '0;
                        end else begin
                            r_sc <= r_sc + SW'(1);
                        end
                    end else begin
                        r_sc <= '0;
                    end
                end
                ST_FORCE: begin
                    r_state <= ST_NORMAL;
                    r_sc    <= '0;
                end
                default: begin
                    r_state <= ST_NORMAL;
                    r_sc    <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios followed by random traffic, all outputs
// compared every cycle against a queue-based reference model of the arbiter.
module tb_regfile_wb_arb;
    localparam int XLEN       = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_LIM = 4;

    logic            clk = 1'b0;
    logic            srst;
    logic            a_valid, b_valid, iss_valid;
    logic [4:0]      a_rd, b_rd, iss_rd, rs1, rs2;
    logic [XLEN-1:0] a_data, b_data;
    logic            a_ready, b_ready, rs1_busy, rs2_busy, wen, dbg_state;
    logic [31:0]     pend;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;

    regfile_wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .srst(srst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .pend(pend),
        .wen(wen), .waddr(waddr), .wdata(wdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents as a queue, the head's bypass count, and the
    // expected write-back/scoreboard outputs for the current cycle.
    logic [XLEN+4:0] m_fifo[$];
    logic            m_force;
    int              m_bypass;
    logic            m_wen;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;
    logic [31:0]     m_pend;
    logic            last_a_acc;
    logic            last_push;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic            a_acc, pop, push;
        logic [4:0]      s_rd;
        logic [XLEN-1:0] s_data;
        logic [XLEN+4:0] head;
        @(negedge clk);
        check("a_ready", 64'(a_ready), 64'(srst ? 1'b1 : !m_force));
        check("b_ready", 64'(b_ready), 64'(!srst && (m_fifo.size() < DEPTH)));
        check("wen", 64'(wen), 64'(m_wen));
        check("waddr", 64'(waddr), 64'(m_waddr));
        check("wdata", 64'(wdata), 64'(m_wdata));
        check("pend", 64'(pend), 64'(m_pend));
        check("rs1_busy", 64'(rs1_busy), 64'(m_pend[rs1]));
        check("rs2_busy", 64'(rs2_busy), 64'(m_pend[rs2]));
        last_a_acc = 1'b0;
        last_push  = 1'b0;
        if (srst) begin
            m_fifo.delete();
            m_force  = 1'b0;
            m_bypass = 0;
            m_wen    = 1'b0;
            m_waddr  = '0;
            m_wdata  = '0;
            m_pend   = '0;
        end else begin
            a_acc = !m_force && a_valid;
            pop   = (m_fifo.size() != 0) && (m_force || !a_valid);
            push  = b_valid && (m_fifo.size() < DEPTH);
            if (m_wen) m_pend[m_waddr] = 1'b0;
            if (iss_valid && iss_rd != 5'd0) m_pend[iss_rd] = 1'b1;
            s_rd   = m_waddr;
            s_data = m_wdata;
            if (a_acc) begin
                s_rd   = a_rd;
                s_data = a_data;
            end else if (pop) begin
                head   = m_fifo[0];
                s_rd   = head[XLEN+4:XLEN];
                s_data = head[XLEN-1:0];
            end
            m_wen   = (a_acc || pop) && (s_rd != 5'd0);
            m_waddr = s_rd;
            m_wdata = s_data;
            if (m_force || m_fifo.size() == 0 || pop) begin
                m_force  = 1'b0;
                m_bypass = 0;
            end else begin
                m_bypass++;
                if (m_bypass == STARVE_LIM) begin
                    m_force  = 1'b1;
                    m_bypass = 0;
                end
            end
            if (pop) void'(m_fifo.pop_front());
            if (push) m_fifo.push_back({b_rd, b_data});
            last_a_acc = a_acc;
            last_push  = push;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_stall;
        int n_w9;
        int waited;
        m_fifo.delete();
        m_force = 1'b0; m_bypass = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_pend = '0;
        last_a_acc = 1'b0; last_push = 1'b0;
        srst = 1'b1; a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h3333; iss_valid = 1'b0; iss_rd = '0;
        rs1 = '0; rs2 = '0;

        // Reset held two cycles with b_valid high; nothing may be pushed.
        cycle(); cycle();
        srst = 1'b0; b_valid = 1'b0;
        cycle();
        check("post_reset_b_ready", 64'(b_ready), 64'd1);
        cycle();
        check("post_reset_no_write", 64'(wen), 64'd0);

        // ALU path with a scoreboard entry on x5.
        rs1 = 5'd5; iss_valid = 1'b1; iss_rd = 5'd5;
        cycle();
        iss_valid = 1'b0;
        cycle(); cycle();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h12345678;
        cycle();
        a_valid = 1'b0;
        check("alu_wen", 64'(wen), 64'd1);
        check("alu_waddr", 64'(waddr), 64'd5);
        check("alu_wdata", 64'(wdata), 64'h12345678);
        check("alu_rs1_busy_c4", 64'(rs1_busy), 64'd1);
        cycle();
        check("alu_rs1_busy_c5", 64'(rs1_busy), 64'd0);

        // FIFO fill/drain with A idle.
        for (int i = 1; i <= 4; i++) begin
            b_valid = 1'b1; b_rd = 5'(i); b_data = 32'hA0 + 32'(i);
            cycle();
        end
        b_valid = 1'b0;
        repeat (3) cycle();

        // Fill to full while A is continuously valid; a 5th push must wait.
        a_valid = 1'b1; a_rd = 5'd20; a_data = 32'hC000;
        for (int i = 0; i < 4; i++) begin
            if (last_a_acc) begin a_rd = a_rd + 5'd1; a_data = a_data + 32'd1; end
            b_valid = 1'b1; b_rd = 5'(11 + i); b_data = 32'hB0 + 32'(i);
            cycle();
        end
        check("fifo_full_b_ready", 64'(b_ready), 64'd0);
        b_rd = 5'd15; b_data = 32'hB5;
        waited = 0;
        last_push = 1'b0;
        while (!last_push && waited < 20) begin
            if (last_a_acc) begin a_rd = a_rd + 5'd1; a_data = a_data + 32'd1; end
            cycle();
            waited++;
        end
        check("fifo_5th_pushed", 64'(last_push), 64'd1);
        b_valid = 1'b0; a_valid = 1'b0;
        repeat (6) cycle();

        // Starvation: one FIFO entry rd=9 under continuous A traffic.
        a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hD0;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
        cycle();
        b_valid = 1'b0;
        n_stall = 0; n_w9 = 0;
        for (int i = 0; i < 10; i++) begin
            if (last_a_acc) begin a_rd = a_rd + 5'd1; a_data = a_data + 32'd1; end
            if (!a_ready) n_stall++;
            cycle();
            if (wen && waddr == 5'd9) n_w9++;
        end
        check("starve_stall_cycles", 64'(n_stall), 64'd1);
        check("starve_rd9_writes", 64'(n_w9), 64'd1);
        a_valid = 1'b0;
        cycle();

        // x0 destination and x0 issue.
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFFFFFF; iss_valid = 1'b1; iss_rd = 5'd0;
        cycle();
        a_valid = 1'b0; iss_valid = 1'b0;
        check("x0_wen", 64'(wen), 64'd0);
        check("x0_pend", 64'(pend), 64'd0);

        // Set/clear collision on x7.
        iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        iss_valid = 1'b0; a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
        cycle();
        a_valid = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7;
        cycle();
        iss_valid = 1'b0;
        check("collision_pend7", 64'(pend[7]), 64'd1);
        cycle();

        // Reset with three FIFO entries queued behind A traffic.
        a_valid = 1'b1; a_rd = 5'd22; a_data = 32'hE0; iss_valid = 1'b1; iss_rd = 5'd12;
        for (int i = 0; i < 3; i++) begin
            if (last_a_acc) begin a_rd = a_rd + 5'd1; a_data = a_data + 32'd1; end
            b_valid = 1'b1; b_rd = 5'(24 + i); b_data = 32'hF0 + 32'(i);
            cycle();
            iss_valid = 1'b0;
        end
        b_valid = 1'b0; a_valid = 1'b0; srst = 1'b1;
        cycle();
        srst = 1'b0;
        repeat (4) cycle();
        check("rst_drain_wen", 64'(wen), 64'd0);
        check("rst_drain_pend", 64'(pend), 64'd0);
        check("rst_drain_b_ready", 64'(b_ready), 64'd1);

        // Random traffic with producers holding payloads until accepted.
        for (int c = 0; c < 400; c++) begin
            if (!a_valid || last_a_acc) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_rd    = 5'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || last_push) begin
                b_valid = ($urandom_range(0, 99) < 40);
                b_rd    = 5'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 3) == 0);
            iss_rd    = 5'($urandom_range(0, 31));
            rs1       = 5'($urandom_range(0, 31));
            rs2       = 5'($urandom_range(0, 31));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
